// File: rtl/rsa_pkg.sv
// Shared encodings and default 192-bit constants for the modular exponentiation path.
// The default modulus is 2^192 - 2^64 - 1, so R = 2^64 + 1 and R^2 = 2^128 + 2^65 + 1.
package rsa_pkg;

   localparam int DEF_K    = 192;
   localparam int DEF_LOGK = 8;
   localparam int DEF_EW   = 192;
   localparam int DEF_LOGEW = 8;

   localparam logic [191:0] DEF_M        = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
   localparam logic [191:0] DEF_R_MOD_M  = 192'h000000000000000000000000000000010000000000000001;
   localparam logic [191:0] DEF_R2_MOD_M = 192'h000000000000000100000000000000020000000000000001;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TO_MONT   = 3'd1,
      SQUARE    = 3'd2,
      MULT      = 3'd3,
      FROM_MONT = 3'd4,
      DONE      = 3'd5
   } exp_state_t;

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      WAIT    = 2'd1,
      RELEASE = 2'd2
   } phase_t;

   typedef enum logic [1:0] {
      MM_IDLE   = 2'd0,
      MM_RUN    = 2'd1,
      MM_ENDING = 2'd2
   } mm_state_t;

endpackage

// File: rtl/mod_exp_if.sv
// Request/response bundle between the exponentiation controller and its client.
interface mod_exp_if import rsa_pkg::*; #(
   parameter int K  = DEF_K,
   parameter int EW = DEF_EW
);
   logic          start;
   logic [K-1:0]  base;
   logic [EW-1:0] exp;
   logic [K-1:0]  result;
   logic          busy;
   logic          done;

   modport master (output start, output base, output exp,
                   input result, input busy, input done);
   modport slave  (input start, input base, input exp,
                   output result, output busy, output done);
endinterface

// File: rtl/mod_mul.sv
// Bit-serial Montgomery multiplier: z = x*y*2^-k mod m, one x bit per cycle.
// y is read combinationally every step, so the caller keeps it stable until done.
module mod_mul import rsa_pkg::*; #(
   parameter int          k    = DEF_K,
   parameter int          logk = DEF_LOGK,
   parameter logic [k-1:0] m   = k'(DEF_M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [k-1:0] x,
   input  logic [k-1:0] y,
   output logic [k-1:0] z,
   output logic         done
);

   mm_state_t     state, state_d;
   logic [k+1:0]  acc, acc_x, acc_q, a_next;
   logic [k-1:0]  xs;
   logic [logk-1:0] cnt;
   logic          last;

   assign last = (cnt == logk'(k - 1));
   assign done = (state == MM_ENDING);

   // acc stays below 2m across steps, so k+2 bits cover acc + y + m
   always_comb begin
      acc_x  = acc + (xs[0] ? {2'b00, y} : '0);
      acc_q  = acc_x + (acc_x[0] ? {2'b00, m} : '0);
      a_next = acc_q >> 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MM_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         MM_IDLE:   if (start) state_d = MM_RUN;
         MM_RUN:    if (last)  state_d = MM_ENDING;
         MM_ENDING: if (!start) state_d = MM_IDLE;
         default:   state_d = MM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         xs  <= '0;
         cnt <= '0;
         z   <= '0;
      end else begin
         case (state)
            MM_IDLE: if (start) begin
               acc <= '0;
               xs  <= x;
               cnt <= '0;
            end
            MM_RUN: begin
               acc <= a_next;
               xs  <= xs >> 1;
               cnt <= cnt + 1'b1;
               if (last)
                  z <= (a_next >= {2'b00, m}) ? k'(a_next - {2'b00, m}) : a_next[k-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// sequencing a single mod_mul through ISSUE/WAIT/RELEASE per multiplication.
module mod_exp import rsa_pkg::*; #(
   parameter int           K        = DEF_K,
   parameter int           LOGK     = DEF_LOGK,
   parameter int           EW       = DEF_EW,
   parameter int           LOGEW    = DEF_LOGEW,
   parameter logic [K-1:0] M        = K'(DEF_M),
   parameter logic [K-1:0] R_MOD_M  = K'(DEF_R_MOD_M),
   parameter logic [K-1:0] R2_MOD_M = K'(DEF_R2_MOD_M)
) (
   input logic      clk,
   input logic      rst_n,
   mod_exp_if.slave io
);

   exp_state_t     state, state_d, nxt;
   phase_t         ph, ph_d;
   logic           mul_start, mul_start_d;
   logic [K-1:0]   mul_x, mul_y, mul_z;
   logic           mul_done;
   logic           start_q, accept, cap, adv, e_bit, step_idx;
   logic [K-1:0]   reg_b, acc, xm, result;
   logic [EW-1:0]  reg_e;
   logic [LOGEW-1:0] idx;

   // reg_e shifts left as idx counts down, so its MSB is always bit idx of exp
   assign e_bit     = reg_e[EW-1];
   assign io.busy   = (state != IDLE) && (state != DONE);
   assign io.done   = (state == DONE);
   assign io.result = result;

   mod_mul #(.k(K), .logk(LOGK), .m(M)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .x     (mul_x),
      .y     (mul_y),
      .z     (mul_z),
      .done  (mul_done)
   );

   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state)
         TO_MONT:   begin mul_x = reg_b; mul_y = R2_MOD_M; end
         SQUARE:    begin mul_x = acc;   mul_y = acc;      end
         MULT:      begin mul_x = acc;   mul_y = xm;       end
         FROM_MONT: begin mul_x = acc;   mul_y = K'(1);    end
         default: ;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         TO_MONT:   nxt = SQUARE;
         SQUARE:    nxt = e_bit ? MULT : ((idx == '0) ? FROM_MONT : SQUARE);
         MULT:      nxt = (idx == '0) ? FROM_MONT : SQUARE;
         FROM_MONT: nxt = DONE;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ph        <= ISSUE;
         mul_start <= 1'b0;
      end else begin
         state     <= state_d;
         ph        <= ph_d;
         mul_start <= mul_start_d;
      end
   end

   always_comb begin
      state_d     = state;
      ph_d        = ph;
      mul_start_d = mul_start;
      accept      = 1'b0;
      cap         = 1'b0;
      adv         = 1'b0;
      case (state)
         IDLE: if (io.start && !start_q) begin
            accept  = 1'b1;
            state_d = TO_MONT;
            ph_d    = ISSUE;
         end
         DONE: state_d = IDLE;
         default: begin
            case (ph)
               ISSUE: begin
                  mul_start_d = 1'b1;
                  ph_d        = WAIT;
               end
               WAIT: if (mul_done) begin
                  cap         = 1'b1;
                  mul_start_d = 1'b0;
                  ph_d        = RELEASE;
               end
               RELEASE: begin
                  adv     = 1'b1;
                  ph_d    = ISSUE;
                  state_d = nxt;
               end
               default: ph_d = ISSUE;
            endcase
         end
      endcase
   end

   assign step_idx = adv && (((state == SQUARE) && !e_bit) || (state == MULT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         reg_b   <= '0;
         reg_e   <= '0;
         acc     <= '0;
         xm      <= '0;
         result  <= '0;
         idx     <= LOGEW'(EW - 1);
      end else begin
         start_q <= io.start;
         if (accept) begin
            reg_b <= io.base;
            reg_e <= io.exp;
            acc   <= R_MOD_M;
            idx   <= LOGEW'(EW - 1);
         end
         if (cap) begin
            case (state)
               TO_MONT:      xm     <= mul_z;
               SQUARE, MULT: acc    <= mul_z;
               FROM_MONT:    result <= mul_z;
               default: ;
            endcase
         end
         if (step_idx) begin
            idx   <= idx - 1'b1;
            reg_e <= reg_e << 1;
         end
      end
   end

endmodule
